// File: rtl/mem2axi.sv
// Single-outstanding, single-beat bridge from a simple memory request port to AXI4.
// Optional response timeout with discard of late responses: define MEM2AXI_TIMEOUT_EN.
module mem2axi #(
    parameter int unsigned ID_WIDTH = 1,
    parameter int unsigned AXI_ID   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic                i_we,
    input  logic [31:0]         i_addr,
    input  logic [7:0]          i_be,
    input  logic [63:0]         i_wdata,
    output logic                o_gnt,
    output logic                o_rvalid,
    output logic [63:0]         o_rdata,
    output logic                o_err,
    output logic [ID_WIDTH-1:0] o_awid,
    output logic [31:0]         o_awaddr,
    output logic [7:0]          o_awlen,
    output logic [2:0]          o_awsize,
    output logic [1:0]          o_awburst,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [63:0]         o_wdata,
    output logic [7:0]          o_wstrb,
    output logic                o_wlast,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [ID_WIDTH-1:0] i_bid,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready,
    output logic [ID_WIDTH-1:0] o_arid,
    output logic [31:0]         o_araddr,
    output logic [7:0]          o_arlen,
    output logic [2:0]          o_arsize,
    output logic [1:0]          o_arburst,
    output logic                o_arvalid,
    input  logic                i_arready,
    input  logic [ID_WIDTH-1:0] i_rid,
    input  logic [63:0]         i_rdata,
    input  logic [1:0]          i_rresp,
    input  logic                i_rlast,
    input  logic                i_rvalid,
    output logic                o_rready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADDR = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;

`ifdef MEM2AXI_TIMEOUT_EN
    localparam bit LP_TMO_EN = 1'b1;
`else
    localparam bit LP_TMO_EN = 1'b0;
`endif

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [31:0] r_addr;
    logic [7:0]  r_be;
    logic [63:0] r_wdata;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_arvalid;
    logic        r_bready;
    logic        r_rready;
    logic        r_rvalid;
    logic        r_err;
    logic [63:0] r_rdata;
    logic        w_tmo;
    logic        w_unused;

`ifdef MEM2AXI_TIMEOUT_EN
    logic [15:0] r_cnt;

    // Wait counter restarts on every state change; only meaningful in WRESP/RDATA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_cnt <= 16'd0;
        else if (w_next != r_state) r_cnt <= 16'd0;
        else                      r_cnt <= r_cnt + 16'd1;
    end
    assign w_tmo = (r_cnt == 16'hFFFF);
`else
    assign w_tmo = 1'b0;
`endif

    assign w_unused = ^{i_bid, i_rid, i_rlast, i_bresp[0], i_rresp[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_req) w_next = i_we ? S_WADDR : S_RADDR;
            // Each channel counts as done once its valid has dropped or is handshaking now.
            S_WADDR: if ((!r_awvalid || i_awready) && (!r_wvalid || i_wready)) w_next = S_WRESP;
            S_WRESP: if (i_bvalid || w_tmo) w_next = S_IDLE;
            S_RADDR: if (i_arready) w_next = S_RDATA;
            S_RDATA: if (i_rvalid || w_tmo) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Channel valids, payload capture and response generation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= 32'd0;
            r_be      <= 8'd0;
            r_wdata   <= 64'd0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_bready  <= 1'b0;
            r_rready  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 64'd0;
        end else begin
            r_rvalid <= 1'b0;
            r_bready <= (w_next == S_WRESP) || (LP_TMO_EN && (w_next == S_IDLE));
            r_rready <= (w_next == S_RDATA) || (LP_TMO_EN && (w_next == S_IDLE));
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_addr <= i_addr;
                        if (i_we) begin
                            r_be      <= i_be;
                            r_wdata   <= i_wdata;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                S_WADDR: begin
                    if (i_awready) r_awvalid <= 1'b0;
                    if (i_wready)  r_wvalid  <= 1'b0;
                end
                S_WRESP: begin
                    if (i_bvalid || w_tmo) begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= 64'd0;
                        r_err    <= i_bvalid ? i_bresp[1] : 1'b1;
                    end
                end
                S_RADDR: if (i_arready) r_arvalid <= 1'b0;
                S_RDATA: begin
                    if (i_rvalid) begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= i_rdata;
                        r_err    <= i_rresp[1];
                    end else if (w_tmo) begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= 64'd0;
                        r_err    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_gnt     = (r_state == S_IDLE) && i_req && !rst;
    assign o_rvalid  = r_rvalid;
    assign o_rdata   = r_rdata;
    assign o_err     = r_err;
    assign o_awid    = ID_WIDTH'(AXI_ID);
    assign o_awaddr  = r_addr;
    assign o_awlen   = 8'd0;
    assign o_awsize  = 3'd3;
    assign o_awburst = 2'b01;
    assign o_awvalid = r_awvalid;
    assign o_wdata   = r_wdata;
    assign o_wstrb   = r_be;
    assign o_wlast   = 1'b1;
    assign o_wvalid  = r_wvalid;
    assign o_bready  = r_bready;
    assign o_arid    = ID_WIDTH'(AXI_ID);
    assign o_araddr  = r_addr;
    assign o_arlen   = 8'd0;
    assign o_arsize  = 3'd3;
    assign o_arburst = 2'b01;
    assign o_arvalid = r_arvalid;
    assign o_rready  = r_rready;

endmodule

// File: tb/tb_mem2axi.sv
// Scoreboard bench for mem2axi: AXI slave model with programmable ready delays and response queue.
module tb_mem2axi;

    logic        clk, rst;
    logic        i_req, i_we;
    logic [31:0] i_addr;
    logic [7:0]  i_be;
    logic [63:0] i_wdata;
    logic        o_gnt, o_rvalid, o_err;
    logic [63:0] o_rdata;
    logic [0:0]  o_awid, o_arid, i_bid, i_rid;
    logic [31:0] o_awaddr, o_araddr;
    logic [7:0]  o_awlen, o_arlen, o_wstrb;
    logic [2:0]  o_awsize, o_arsize;
    logic [1:0]  o_awburst, o_arburst, i_bresp, i_rresp;
    logic        o_awvalid, i_awready, o_wlast, o_wvalid, i_wready;
    logic        i_bvalid, o_bready, o_arvalid, i_arready;
    logic [63:0] o_wdata, i_rdata;
    logic        i_rlast, i_rvalid, o_rready;

    mem2axi dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_be(i_be),
        .i_wdata(i_wdata), .o_gnt(o_gnt), .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_err(o_err),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
        .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
        .i_wready(i_wready), .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid),
        .o_bready(o_bready), .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen),
        .o_arsize(o_arsize), .o_arburst(o_arburst), .o_arvalid(o_arvalid),
        .i_arready(i_arready), .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp),
        .i_rlast(i_rlast), .i_rvalid(i_rvalid), .o_rready(o_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_rsp  = 0;
    int n_aw   = 0;
    int n_w    = 0;
    int n_ar   = 0;
    logic [64:0] sb[$];

    // slave model knobs and expectations
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    bit          b_hold = 1'b0;
    int          b_pend = 0, r_pend = 0;
    logic [1:0]  cur_bresp = 2'b00, cur_rresp = 2'b00;
    logic [63:0] cur_rdata = 64'd0;
    logic [31:0] exp_addr;
    logic [7:0]  exp_be;
    logic [63:0] exp_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else             n_pass++;
    endtask

    // AXI slave: readies decided at negedge, handshakes take effect on the following posedge.
    initial begin
        int  aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
        bit  aw_pv = 0, aw_pr = 0, w_pv = 0, w_pr = 0, ar_pv = 0, ar_pr = 0;
        logic [31:0] aw_pa = 0, ar_pa = 0;
        logic [63:0] w_pd = 0;
        i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0;
        i_bresp = 0; i_rresp = 0; i_rdata = 0; i_rlast = 1; i_bid = 0; i_rid = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_pv = 0; w_pv = 0; ar_pv = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0;
                continue;
            end
            if (aw_pv && !aw_pr) begin
                check("awvalid_hold", 64'(o_awvalid), 64'd1);
                check("awaddr_stable", 64'(o_awaddr), 64'(aw_pa));
            end
            if (aw_pv && aw_pr) check("awvalid_drop", 64'(o_awvalid), 64'd0);
            if (w_pv && !w_pr) begin
                check("wvalid_hold", 64'(o_wvalid), 64'd1);
                check("wdata_stable", o_wdata, w_pd);
            end
            if (w_pv && w_pr) check("wvalid_drop", 64'(o_wvalid), 64'd0);
            if (ar_pv && !ar_pr) begin
                check("arvalid_hold", 64'(o_arvalid), 64'd1);
                check("araddr_stable", 64'(o_araddr), 64'(ar_pa));
            end
            if (ar_pv && ar_pr) check("arvalid_drop", 64'(o_arvalid), 64'd0);

            if (o_awvalid) begin i_awready = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin i_awready = 0; aw_cnt = 0; end
            if (o_wvalid) begin i_wready = (w_cnt >= w_delay); w_cnt++; end
            else begin i_wready = 0; w_cnt = 0; end
            if (o_arvalid) begin i_arready = (ar_cnt >= ar_delay); ar_cnt++; end
            else begin i_arready = 0; ar_cnt = 0; end

            if (o_awvalid && i_awready) begin
                n_aw++;
                check("awaddr", 64'(o_awaddr), 64'(exp_addr));
                check("aw_attr", 64'({o_awid, o_awlen, o_awsize, o_awburst}), 64'({1'b0, 8'd0, 3'd3, 2'b01}));
            end
            if (o_wvalid && i_wready) begin
                n_w++; b_pend++;
                check("wdata", o_wdata, exp_wdata);
                check("wstrb_wlast", 64'({o_wstrb, o_wlast}), 64'({exp_be, 1'b1}));
            end
            if (o_arvalid && i_arready) begin
                n_ar++; r_pend++;
                check("araddr", 64'(o_araddr), 64'(exp_addr));
                check("ar_attr", 64'({o_arid, o_arlen, o_arsize, o_arburst}), 64'({1'b0, 8'd0, 3'd3, 2'b01}));
            end

            i_bresp  = cur_bresp;
            i_bvalid = o_bready && (b_pend > 0) && !b_hold;
            if (i_bvalid) b_pend--;
            i_rresp  = cur_rresp;
            i_rdata  = cur_rdata;
            i_rvalid = o_rready && (r_pend > 0);
            if (i_rvalid) r_pend--;

            aw_pv = o_awvalid; aw_pr = i_awready; aw_pa = o_awaddr;
            w_pv  = o_wvalid;  w_pr  = i_wready;  w_pd  = o_wdata;
            ar_pv = o_arvalid; ar_pr = i_arready; ar_pa = o_araddr;
        end
    end

    // Response monitor: every o_rvalid pulse is matched against the scoreboard.
    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (!rst && o_rvalid) begin
                n_rsp++;
                if (sb.size() == 0) check("unexpected_rsp", 64'd1, 64'd0);
                else begin
                    e = sb.pop_front();
                    check("rsp_err", 64'(o_err), 64'(e[64]));
                    check("rsp_rdata", o_rdata, e[63:0]);
                end
            end
        end
    end

    // Caller must be at a negedge; returns just after the grant edge with i_req dropped.
    task automatic issue(input bit we, input logic [31:0] addr, input logic [7:0] be,
                         input logic [63:0] wd, input bit e_err, input logic [63:0] e_rd);
        exp_addr = addr; exp_be = be; exp_wdata = wd;
        sb.push_back({e_err, e_rd});
        i_req = 1; i_we = we; i_addr = addr; i_be = be; i_wdata = wd;
        #1 check("gnt", 64'(o_gnt), 64'd1);
        @(posedge clk);
        #1 i_req = 0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [7:0] be, input logic [63:0] wd,
                      input logic [1:0] bresp);
        cur_bresp = bresp;
        issue(1'b1, addr, be, wd, bresp[1], 64'd0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [63:0] rdat, input logic [1:0] rresp);
        cur_rdata = rdat; cur_rresp = rresp;
        issue(1'b0, addr, 8'h00, 64'd0, rresp[1], rdat);
    endtask

    // Latency counted in cycles from the grant cycle; ends at the negedge where o_rvalid is seen.
    task automatic wait_rsp(input int max, output int lat, output bit got);
        lat = 1; got = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (o_rvalid) begin got = 1; break; end
            @(posedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        bit got;
        int aw0, w0, rsp0;
        rst = 1; i_req = 0; i_we = 0; i_addr = 0; i_be = 0; i_wdata = 0;
        repeat (2) @(negedge clk);
        check("rst_valids", 64'({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}), 64'd0);
        check("rst_rsp", 64'({o_gnt, o_rvalid, o_err}), 64'd0);
        check("rst_rdata", o_rdata, 64'd0);
        rst = 0;
        @(negedge clk);

        // plain write, all readies immediate
        aw0 = n_aw; w0 = n_w;
        wr(32'h8000_1010, 8'hFF, 64'h1122_3344_5566_7788, 2'b00);
        wait_rsp(20, lat, got);
        check("wr_got", 64'(got), 64'd1);
        check("wr_lat", 64'(lat), 64'd3);
        repeat (3) @(negedge clk);
        check("wr_one_aw", 64'(n_aw - aw0), 64'd1);
        check("wr_one_w", 64'(n_w - w0), 64'd1);

        // plain read
        rd(32'h8000_1000, 64'hDEAD_BEEF_00FF_0101, 2'b00);
        wait_rsp(20, lat, got);
        check("rd_got", 64'(got), 64'd1);
        check("rd_lat", 64'(lat), 64'd3);
        repeat (3) @(negedge clk);
        check("rdata_hold", o_rdata, 64'hDEAD_BEEF_00FF_0101);

        // W accepted three cycles before AW, then the reverse order
        aw_delay = 3; w_delay = 0; aw0 = n_aw; w0 = n_w; rsp0 = n_rsp;
        wr(32'h0000_0A08, 8'h0F, 64'hA5A5_0000_FFFF_1234, 2'b00);
        wait_rsp(30, lat, got);
        check("wfirst_got", 64'(got), 64'd1);
        aw_delay = 0; w_delay = 2;
        @(negedge clk);
        wr(32'h0000_0B10, 8'hF0, 64'h0BAD_F00D_CAFE_0001, 2'b01);
        wait_rsp(30, lat, got);
        check("awfirst_got", 64'(got), 64'd1);
        w_delay = 0;
        repeat (5) @(negedge clk);
        check("stall_aw_cnt", 64'(n_aw - aw0), 64'd2);
        check("stall_w_cnt", 64'(n_w - w0), 64'd2);
        check("stall_rsp_cnt", 64'(n_rsp - rsp0), 64'd2);

        // error responses, each following request granted in the o_rvalid cycle
        wr(32'h0000_0100, 8'h01, 64'h0000_0000_0000_00EE, 2'b10);
        wait_rsp(20, lat, got);
        check("berr_got", 64'(got), 64'd1);
        rd(32'h0000_0200, 64'h0123_4567_89AB_CDEF, 2'b11);
        wait_rsp(20, lat, got);
        check("rerr_lat", 64'(lat), 64'd3);
        wr(32'h0000_0300, 8'h80, 64'h7700_0000_0000_0000, 2'b00);
        wait_rsp(20, lat, got);
        check("b2b_wr_lat", 64'(lat), 64'd3);
        @(negedge clk);

        // reset while AR is stalled
        ar_delay = 100;
        rd(32'h8000_2000, 64'h5555_AAAA_5555_AAAA, 2'b00);
        repeat (2) @(negedge clk);
        check("pre_rst_arvalid", 64'(o_arvalid), 64'd1);
        #2 rst = 1;
        #1;
        check("mid_rst_valids", 64'({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}), 64'd0);
        check("mid_rst_rsp", 64'({o_gnt, o_rvalid, o_err}), 64'd0);
        check("mid_rst_data", o_rdata | 64'(o_araddr), 64'd0);
        sb.delete();
        @(negedge clk);
        #2 rst = 0;
        ar_delay = 0; rsp0 = n_rsp;
        repeat (20) @(negedge clk);
        check("no_rsp_after_rst", 64'(n_rsp - rsp0), 64'd0);

        // withheld write response
        b_hold = 1;
`ifdef MEM2AXI_TIMEOUT_EN
        cur_bresp = 2'b00;
        issue(1'b1, 32'h0000_0400, 8'hFF, 64'h1, 1'b1, 64'd0);
        wait_rsp(70000, lat, got);
        check("tmo_got", 64'(got), 64'd1);
        rsp0 = n_rsp;
        @(negedge clk);
        b_hold = 0;
        repeat (10) @(negedge clk);
        check("late_b_consumed", 64'(b_pend), 64'd0);
        check("late_b_silent", 64'(n_rsp - rsp0), 64'd0);
`else
        wr(32'h0000_0400, 8'hFF, 64'h1, 2'b00);
        wait_rsp(70000, lat, got);
        check("no_tmo_rsp", 64'(got), 64'd0);
        b_hold = 0;
        wait_rsp(20, lat, got);
        check("held_b_rsp", 64'(got), 64'd1);
        repeat (5) @(negedge clk);
`endif
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
